// File: rtl/dcpu_bus_arbiter_if.sv
// Wishbone-style point-to-point bus bundle used between the DCPU masters, the arbiter and the
// memory slave.
//   addr  : master -> slave  address
//   cyc   : master -> slave  cycle request / hold
//   stb   : master -> slave  byte strobes
//   we    : master -> slave  write enable
//   dat_w : master -> slave  write data
//   dat_r : slave  -> master read data
//   ack   : slave  -> master transfer acknowledge
//   err   : slave  -> master transfer error
// The arbiter uses the slave modport toward each CPU master and the master modport toward memory.
interface dcpu_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned SW = 4
);
    logic [AW-1:0] addr;
    logic          cyc;
    logic [SW-1:0] stb;
    logic          we;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          err;

    modport master (
        output addr, cyc, stb, we, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  addr, cyc, stb, we, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/dcpu_bus_arbiter.sv
// Shares the single Wishbone memory port between the instruction fetcher (m0) and the
// load/store unit (m1). Round-robin grant; the owner keeps the bus for as long as it holds cyc.
// A watchdog aborts a transfer the slave never answers and reports it to the owner as err.
//   i_clk    : clock, rising edge
//   i_reset  : synchronous, active-high reset
//   m0       : fetcher request bus (arbiter acts as its slave)
//   m1       : load/store request bus (arbiter acts as its slave)
//   s        : memory bus (arbiter acts as its master)
//   o_busy   : high whenever the arbiter is not idle
module dcpu_bus_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SW      = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    dcpu_bus_arbiter_if.slave  m0,
    dcpu_bus_arbiter_if.slave  m1,
    dcpu_bus_arbiter_if.master s,
    output logic               o_busy
);
    localparam int unsigned   WW       = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WdogLast = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StBusy0, StBusy1, StAbort0, StAbort1} state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          abort_err_q, abort_err_d;

    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_stb;
    logic [DW-1:0] s_dat;
    logic          s_cyc;
    logic          s_we;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            abort_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            abort_err_q  <= abort_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wdog_d       = '0;
        abort_err_d  = 1'b0;
        s_addr       = '0;
        s_stb        = '0;
        s_dat        = '0;
        s_cyc        = 1'b0;
        s_we         = 1'b0;
        m0_ack       = 1'b0;
        m0_err       = 1'b0;
        m1_ack       = 1'b0;
        m1_err       = 1'b0;
        busy         = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (m0.cyc && m1.cyc) begin
                    // Contention: the master that did not own the bus last time wins.
                    if (last_grant_q) begin
                        state_d      = StBusy0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = StBusy1;
                        last_grant_d = 1'b1;
                    end
                end else if (m0.cyc) begin
                    state_d      = StBusy0;
                    last_grant_d = 1'b0;
                end else if (m1.cyc) begin
                    state_d      = StBusy1;
                    last_grant_d = 1'b1;
                end
            end

            StBusy0: begin
                s_addr = m0.addr;
                s_stb  = m0.stb;
                s_dat  = m0.dat_w;
                s_we   = m0.we;
                s_cyc  = m0.cyc;
                m0_ack = s.ack & m0.cyc;
                m0_err = s.err & m0.cyc;
                if (!m0.cyc) begin
                    state_d = StIdle;
                end else if (!s.ack && !s.err) begin
                    if (wdog_q == WdogLast) begin
                        state_d     = StAbort0;
                        abort_err_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end

            StBusy1: begin
                s_addr = m1.addr;
                s_stb  = m1.stb;
                s_dat  = m1.dat_w;
                s_we   = m1.we;
                s_cyc  = m1.cyc;
                m1_ack = s.ack & m1.cyc;
                m1_err = s.err & m1.cyc;
                if (!m1.cyc) begin
                    state_d = StIdle;
                end else if (!s.ack && !s.err) begin
                    if (wdog_q == WdogLast) begin
                        state_d     = StAbort1;
                        abort_err_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end

            // Slave released; late responses are swallowed until the owner lets go of cyc.
            StAbort0: begin
                m0_err = abort_err_q;
                if (!m0.cyc) begin
                    state_d = StIdle;
                end
            end

            StAbort1: begin
                m1_err = abort_err_q;
                if (!m1.cyc) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Reset is synchronous, so the state may still be busy this cycle: keep the bus quiet.
        if (i_reset) begin
            s_addr = '0;
            s_stb  = '0;
            s_dat  = '0;
            s_cyc  = 1'b0;
            s_we   = 1'b0;
            m0_ack = 1'b0;
            m0_err = 1'b0;
            m1_ack = 1'b0;
            m1_err = 1'b0;
            busy   = 1'b0;
        end
    end

    assign s.addr   = s_addr;
    assign s.stb    = s_stb;
    assign s.dat_w  = s_dat;
    assign s.cyc    = s_cyc;
    assign s.we     = s_we;
    assign m0.ack   = m0_ack;
    assign m0.err   = m0_err;
    assign m0.dat_r = s.dat_r;
    assign m1.ack   = m1_ack;
    assign m1.err   = m1_err;
    assign m1.dat_r = s.dat_r;
    assign o_busy   = busy;
endmodule
